// File: rtl/input_debouncer.sv
// -----------------------------------------------------------------------------
// input_debouncer
//
// Multi-channel debouncer for asynchronous raw inputs such as buttons or
// external reset pins. Each channel is first brought into the clock domain by
// a short flip-flop chain. It then has to hold a value that differs from the
// current debounced level for 2^WIDTH consecutive cycles before the level
// follows it. Any sample that agrees with the current level throws away the
// partial count, so a short glitch never moves the level.
//
// Parameters
//   CHANNELS    : number of independent channels (1..32)
//   WIDTH       : stability counter width; debounce time is 2^WIDTH cycles
//   SYNC_STAGES : synchronizer depth per channel (2..4)
//   INIT        : reset value of each channel's debounced level
//
// Ports
//   clock : single clock; all state changes occur on its rising edge
//   reset : synchronous, active-high reset (wins over every other update)
//   pins  : asynchronous raw inputs, one bit per channel
//   level : registered debounced level per channel
//   rise  : one-cycle pulse after level goes 0->1
//   fall  : one-cycle pulse after level goes 1->0
//   busy  : high while the channel's stability counter is nonzero
// -----------------------------------------------------------------------------
module input_debouncer #(
    parameter int                  CHANNELS    = 4,
    parameter int                  WIDTH       = 16,
    parameter int                  SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0] INIT        = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] pins,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] busy
);

    localparam int              SYNC_W  = SYNC_STAGES * CHANNELS;
    localparam int              CNT_W   = CHANNELS * WIDTH;
    localparam logic [WIDTH-1:0] CNT_MAX = '1;
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    // Synchronizer chain, packed by stage: stage k occupies bits
    // [k*CHANNELS +: CHANNELS]; stage 0 samples pins, the top stage is the
    // synchronized value. Stages reset to INIT so a pin already sitting at
    // its INIT value does not start a count after release.
    logic [SYNC_W-1:0]   sync_chain_r = {SYNC_STAGES{INIT}};
    logic [CHANNELS-1:0] sync_s;

    // Per-channel stability counters, packed as [i*WIDTH +: WIDTH].
    logic [CNT_W-1:0]    cnt_r = '0;
    logic [CNT_W-1:0]    cnt_next_s;

    logic [CHANNELS-1:0] level_r = INIT;
    logic [CHANNELS-1:0] rise_r  = '0;
    logic [CHANNELS-1:0] fall_r  = '0;
    logic [CHANNELS-1:0] busy_r  = '0;
    logic [CHANNELS-1:0] level_next_s;
    logic [CHANNELS-1:0] busy_next_s;

    assign sync_s = sync_chain_r[SYNC_W-1 -: CHANNELS];

    // Per-channel counter update and level toggle on counter carry.
    always_comb begin
        level_next_s = level_r;
        cnt_next_s   = '0;
        busy_next_s  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sync_s[i] != level_r[i]) begin
                if (cnt_r[i*WIDTH +: WIDTH] == CNT_MAX) begin
                    // Carry: the counter wraps and the only effect is the toggle.
                    level_next_s[i]            = ~level_r[i];
                    cnt_next_s[i*WIDTH +: WIDTH] = CNT_ZERO;
                end else begin
                    level_next_s[i]            = level_r[i];
                    cnt_next_s[i*WIDTH +: WIDTH] = cnt_r[i*WIDTH +: WIDTH] + CNT_ONE;
                end
            end else begin
                // Agreement with the level discards any partial count.
                level_next_s[i]            = level_r[i];
                cnt_next_s[i*WIDTH +: WIDTH] = CNT_ZERO;
            end
            busy_next_s[i] = (cnt_next_s[i*WIDTH +: WIDTH] != CNT_ZERO);
        end
    end

    // State registers: synchronizer, counters, level and edge pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_chain_r <= {SYNC_STAGES{INIT}};
            cnt_r        <= '0;
            level_r      <= INIT;
            rise_r       <= '0;
            fall_r       <= '0;
            busy_r       <= '0;
        end else begin
            sync_chain_r <= {sync_chain_r[SYNC_W-CHANNELS-1:0], pins};
            cnt_r        <= cnt_next_s;
            level_r      <= level_next_s;
            rise_r       <= level_next_s & ~level_r;
            fall_r       <= ~level_next_s & level_r;
            busy_r       <= busy_next_s;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;
    assign busy  = busy_r;

endmodule

// File: tb/tb_input_debouncer.sv
// -----------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer with CHANNELS=4, WIDTH=2 (debounce of
// 4 cycles), SYNC_STAGES=2, INIT=4'b0001. Inputs change #1 after a rising
// edge; outputs are sampled at the same point, so "after step N" means the
// state produced by the Nth rising edge since the inputs were last changed.
// -----------------------------------------------------------------------------
module tb_input_debouncer;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] pins  = 4'b0001;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] busy;

    int compared   = 0;
    int mismatched = 0;

    input_debouncer #(
        .CHANNELS    (4),
        .WIDTH       (2),
        .SYNC_STAGES (2),
        .INIT        (4'b0001)
    ) dut (
        .clock (clock),
        .reset (reset),
        .pins  (pins),
        .level (level),
        .rise  (rise),
        .fall  (fall),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [3:0] observed,
                         input logic [3:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    initial begin
        // ---- Reset hold: pins equal INIT, nothing may move ----
        reset = 1'b1;
        pins  = 4'b0001;
        step(3);
        check("rst_level", level, 4'b0001);
        check("rst_rise",  rise,  4'b0000);
        check("rst_fall",  fall,  4'b0000);
        check("rst_busy",  busy,  4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("hold_level", level, 4'b0001);
            check("hold_flags", rise | fall | busy, 4'b0000);
        end

        // ---- Clean step on channel 1: level moves after edge 6 ----
        pins = 4'b0011;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("step_level_pre", level, 4'b0001);
            check("step_rise_pre",  rise,  4'b0000);
            if (k == 3) check("step_busy", busy, 4'b0010);
        end
        step(1);
        check("step_level", level, 4'b0011);
        check("step_rise",  rise,  4'b0010);
        check("step_fall",  fall,  4'b0000);
        check("step_busy0", busy,  4'b0000);
        step(1);
        check("step_rise_gone", rise,  4'b0000);
        check("step_level_hold", level, 4'b0011);

        // ---- Release from INIT with pins low: channel 0 falls after edge 6 ----
        reset = 1'b1;
        pins  = 4'b0000;
        step(2);
        check("rel_rst_level", level, 4'b0001);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("rel_level_pre", level, 4'b0001);
            check("rel_fall_pre",  fall,  4'b0000);
        end
        step(1);
        check("rel_level", level, 4'b0000);
        check("rel_fall",  fall,  4'b0001);
        check("rel_rise",  rise,  4'b0000);
        step(1);
        check("rel_fall_gone", fall, 4'b0000);

        // ---- Glitch on channel 2: three samples high is rejected ----
        pins = 4'b0100;
        step(3);
        check("glitch_busy", busy, 4'b0100);
        pins = 4'b0000;
        for (int k = 4; k <= 10; k++) begin
            step(1);
            check("glitch_level", level, 4'b0000);
            check("glitch_rise",  rise,  4'b0000);
            if (k == 5) check("glitch_busy_hi", busy, 4'b0100);
            if (k == 6) check("glitch_busy_lo", busy, 4'b0000);
        end

        // ---- Four samples high is accepted, then it debounces back low ----
        pins = 4'b0100;
        step(4);
        pins = 4'b0000;
        step(1);
        check("accept_level_pre", level, 4'b0000);
        step(1);
        check("accept_level", level, 4'b0100);
        check("accept_rise",  rise,  4'b0100);
        step(1);
        check("accept_rise_gone", rise, 4'b0000);
        step(3);
        check("accept_back_level", level, 4'b0000);
        check("accept_back_fall",  fall,  4'b0100);

        // ---- Reset mid-count on channel 3 ----
        pins = 4'b1000;
        step(4);
        check("mid_busy", busy, 4'b1000);
        reset = 1'b1;
        step(1);
        check("mid_rst_level", level, 4'b0001);
        check("mid_rst_busy",  busy,  4'b0000);
        check("mid_rst_pulse", rise | fall, 4'b0000);
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step(1);
            check("mid_level_pre", level, 4'b0001);
            check("mid_rise_pre",  rise,  4'b0000);
            if (k == 3) check("mid_busy_restart", busy, 4'b1001);
        end
        step(1);
        check("mid_level", level, 4'b1000);
        check("mid_rise",  rise,  4'b1000);
        check("mid_fall",  fall,  4'b0001);

        // ---- Simultaneous: all four channels toggle together ----
        reset = 1'b1;
        pins  = 4'b0001;
        step(2);
        reset = 1'b0;
        step(3);
        check("sim_idle_busy", busy, 4'b0000);
        pins = 4'b1110;
        step(5);
        check("sim_level_pre", level, 4'b0001);
        check("sim_busy",      busy,  4'b1111);
        step(1);
        check("sim_level", level, 4'b1110);
        check("sim_rise",  rise,  4'b1110);
        check("sim_fall",  fall,  4'b0001);
        step(1);
        check("sim_pulse_gone", rise | fall, 4'b0000);
        check("sim_level_hold", level, 4'b1110);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, giving the number of independent input channels (1..32).
REQ-002 The block SHALL have parameter WIDTH, default 16, giving the per-channel stability counter width; debounce time is 2^WIDTH cycles (1..24).
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer flip-flop depth per channel (2..4).
REQ-004 The block SHALL have parameter INIT, default all zeros, CHANNELS bits wide, giving the reset value of each channel's debounced level.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port pins, input, CHANNELS bits: asynchronous raw inputs such as buttons or external reset pins.
REQ-008 The block SHALL have port level, output, CHANNELS bits: registered debounced level of each channel.
REQ-009 The block SHALL have port rise, output, CHANNELS bits: one-cycle pulse when level goes 0->1.
REQ-010 The block SHALL have port fall, output, CHANNELS bits: one-cycle pulse when level goes 1->0.
REQ-011 The block SHALL have port busy, output, CHANNELS bits: high while the channel counter is nonzero.

Function
REQ-012 Each channel SHALL pass pins[i] through a SYNC_STAGES-deep flip-flop chain; the last stage is sync[i], and no other logic samples pins.
REQ-013 On each edge where sync[i] != level[i], counter[i] SHALL increment by 1.
REQ-014 On each edge where sync[i] == level[i], counter[i] SHALL clear to 0 (glitch rejection; no partial credit retained).
REQ-015 On the edge where sync[i] != level[i] and counter[i] == 2^WIDTH-1, level[i] SHALL invert and counter[i] SHALL wrap to 0 in the same edge.
REQ-016 Latency from a clean, stable pin change (first sampling edge = edge 1) to the level change SHALL be exactly SYNC_STAGES + 2^WIDTH edges.
REQ-017 A pin excursion whose synchronized width is shorter than 2^WIDTH cycles SHALL leave level unchanged.
REQ-018 rise[i] SHALL be 1 for exactly the one cycle following the edge on which level[i] went 0->1, and 0 otherwise; fall[i] likewise for 1->0.
REQ-019 rise[i] and fall[i] SHALL never both be 1.
REQ-020 The counter SHALL never exceed 2^WIDTH-1, and the carry SHALL drive only the level toggle.
REQ-021 Channels SHALL be fully independent; simultaneous toggles on any subset of channels SHALL each produce their own pulse in the same cycle.
REQ-022 busy[i] SHALL equal (counter[i] != 0), registered with the counter.

Reset
REQ-023 While reset is 1 at an edge, the block SHALL set level = INIT, rise = 0, fall = 0, every counter = 0 and busy = 0.
REQ-024 While reset is 1 at an edge, every synchronizer stage of channel i SHALL be set to INIT[i], so a pin already equal to INIT produces no count after release.
REQ-025 Reset asserted mid-count SHALL abort the count with no level change or pulse; after release, counting restarts from 0 and needs the full REQ-016 latency.
REQ-026 Reset SHALL take priority over all other updates on the same edge.
REQ-027 All registers SHALL also carry initial values equal to their reset values.

Verification (CHANNELS=4, WIDTH=2, SYNC_STAGES=2, INIT=4'b0001)
REQ-028 Reset hold: reset=1 for 3 edges, pins=4'b0001 -> level=0001, rise=fall=busy=0000, and these stay unchanged for 20 edges after release.
REQ-029 Clean step: after reset, pins=4'b0011 from edge 1 -> level[1] becomes 1 after edge 6, rise=0010 for exactly that one cycle, other channels unchanged.
REQ-030 Release from INIT: reset released with pins=4'b0000 -> level[0] becomes 0 after edge 6, fall=0001 for one cycle.
REQ-031 Glitch: pins[2]=1 for 3 edges then 0 -> busy[2] pulses, level[2] stays 0, no rise; pins[2]=1 for 4 edges -> level[2] goes to 1.
REQ-032 Reset mid-count: pins[3]=1 and reset=1 on the edge where counter[3]=2 -> level[3]=0, busy[3]=0, no pulse; with pins[3]=1 held, level[3] rises 6 edges after release.
REQ-033 Simultaneous: pins change from 4'b0001 to 4'b1110 in one cycle -> rise=1110 and fall=0001 in the same cycle, 6 edges later.
